// File: rtl/stream_pushr_n.sv
// stream_pushr_n
//   Inserts a prefix of up to N words in front of a stream. A load captures
//   the words in dIn and the number of valid words in dIn_count. The block
//   emits those words on sOut, word 0 first, and then passes sIn through to
//   sOut combinationally. The load can be repeated at any time outside the
//   prefix phase. out_valid is raised once each prefix has been fully sent.
//
// Parameters
//   W  : word width of the stream and of each pushed word
//   N  : maximum number of pushed words per load
//   CW : width of dIn_count
//
// Ports
//   clk        clock
//   nrst       synchronous active-low reset
//   in_valid   load request (dIn, dIn_count)
//   in_ready   load can be accepted (low only while the prefix is emitted)
//   out_valid  prefix-complete acknowledge
//   out_ready  consumer takes the acknowledge
//   dIn        pushed words, word i at dIn[i*W +: W]
//   dIn_count  number of valid words in dIn; values above N saturate to N
//   sIn        input stream data; sIn_valid/sIn_ready form its handshake
//   sOut       output stream data; sOut_valid/sOut_ready form its handshake
module stream_pushr_n #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  input  logic [N*W-1:0] dIn,
  input  logic [CW-1:0]  dIn_count,
  input  logic [W-1:0]   sIn,
  input  logic           sIn_valid,
  output logic           sIn_ready,
  output logic [W-1:0]   sOut,
  output logic           sOut_valid,
  input  logic           sOut_ready
);

  typedef enum logic [1:0] {IDLE, PREFIX, PASS} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic [N*W-1:0]  buf_q;
  logic [CW-1:0]   cnt_sat;
  logic            load;

  // Clamp a requested word count to the buffer depth.
  function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] c);
    if (c > CW'(N)) return CW'(N);
    return c;
  endfunction

  assign cnt_sat = sat_count(dIn_count);
  assign load    = in_valid & in_ready;

  // Output decode. While nrst is low the block already presents its idle
  // face, even before the reset edge has updated the state.
  always_comb begin
    in_ready   = 1'b1;
    out_valid  = 1'b0;
    sOut       = '0;
    sOut_valid = 1'b0;
    sIn_ready  = 1'b0;
    if (nrst) begin
      in_ready  = (state_q != PREFIX);
      out_valid = ack_q;
      case (state_q)
        PREFIX: begin
          sOut       = buf_q[idx_q*W +: W];
          sOut_valid = 1'b1;
        end
        PASS: begin
          sOut       = sIn;
          sOut_valid = sIn_valid;
          sIn_ready  = sOut_ready;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic. A load overrides everything else, including a pending
  // acknowledge, which is cleared and re-raised when the new prefix ends.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    if (ack_q && out_ready) ack_d = 1'b0;
    if (load) begin
      idx_d = '0;
      cnt_d = cnt_sat;
      if (cnt_sat != '0) begin
        state_d = PREFIX;
        ack_d   = 1'b0;
      end else begin
        state_d = PASS;
        ack_d   = 1'b1;
      end
    end else if (state_q == PREFIX && sOut_ready) begin
      idx_d = idx_q + CW'(1);
      if (idx_q == cnt_q - CW'(1)) begin
        state_d = PASS;
        ack_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  // Prefix word storage; contents only matter after a load, so no reset.
  always_ff @(posedge clk) begin
    if (load) buf_q <= dIn;
  end

endmodule

// File: tb/tb_stream_pushr_n.sv
module tb_stream_pushr_n;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic           clk;
  logic           nrst;
  logic           in_valid;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] dIn;
  logic [CW-1:0]  dIn_count;
  logic [W-1:0]   sIn;
  logic           sIn_valid;
  logic           sIn_ready;
  logic [W-1:0]   sOut;
  logic           sOut_valid;
  logic           sOut_ready;

  int n_assert = 0;
  int n_fail   = 0;

  stream_pushr_n #(.W(W), .N(N), .CW(CW)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dIn        (dIn),
    .dIn_count  (dIn_count),
    .sIn        (sIn),
    .sIn_valid  (sIn_valid),
    .sIn_ready  (sIn_ready),
    .sOut       (sOut),
    .sOut_valid (sOut_valid),
    .sOut_ready (sOut_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then driven and outputs
  // sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic bp_rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] bp_exp [5] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33};

  initial begin
    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dIn = '0; dIn_count = '0;
    sIn = '0; sIn_valid = 1'b0; sOut_ready = 1'b0;

    // Reset
    tick();
    tick();
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sOut_valid", sOut_valid, 0);
    chk("rst_sIn_ready", sIn_ready, 0);
    chk("rst_sOut", sOut, 0);
    nrst = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_sOut_valid", sOut_valid, 0);

    // Basic prefix of four words
    dIn = {8'd4, 8'd3, 8'd2, 8'd1}; dIn_count = 3'd4; in_valid = 1'b1;
    sOut_ready = 1'b1; sIn_valid = 1'b1; sIn = 8'd1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("pre_sOut", sOut, k + 1);
      chk("pre_sOut_valid", sOut_valid, 1);
      chk("pre_sIn_ready", sIn_ready, 0);
      chk("pre_in_ready", in_ready, 0);
      chk("pre_out_valid", out_valid, 0);
      tick();
    end
    // Pass-through with the acknowledge held
    for (int j = 1; j <= 3; j++) begin
      sIn = 8'(j);
      #1;
      chk("pass_sOut", sOut, j);
      chk("pass_sIn_ready", sIn_ready, 1);
      chk("ack_hold", out_valid, 1);
      tick();
    end
    sIn = 8'd4;
    out_ready = 1'b1;
    #1;
    chk("ack_before_take", out_valid, 1);
    tick();
    out_ready = 1'b0;
    #1;
    chk("ack_taken", out_valid, 0);
    chk("pass_after_ack", sOut, 4);

    // Mid-stream re-load
    sIn = 8'd9;
    dIn = {8'd0, 8'd0, 8'd0, 8'd42}; dIn_count = 3'd1; in_valid = 1'b1;
    #1;
    chk("reload_in_ready", in_ready, 1);
    chk("reload_sOut9", sOut, 9);
    chk("reload_sIn_ready", sIn_ready, 1);
    tick();
    in_valid = 1'b0; sIn = 8'd10;
    #1;
    chk("reload_sOut42", sOut, 42);
    chk("reload_sIn_ready0", sIn_ready, 0);
    chk("reload_out_valid0", out_valid, 0);
    tick();
    chk("reload_sOut10", sOut, 10);
    chk("reload_ack", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("reload_ack_clr", out_valid, 0);

    // Count zero goes straight to pass-through
    sIn = 8'd20; dIn_count = 3'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("cnt0_sOut", sOut, 20);
    chk("cnt0_sIn_ready", sIn_ready, 1);
    chk("cnt0_out_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("cnt0_ack_clr", out_valid, 0);

    // Count 7 saturates to 4 words
    dIn = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; dIn_count = 3'd7; in_valid = 1'b1;
    sIn = 8'h55;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("sat_sOut", sOut, 8'hA0 + k);
      chk("sat_sIn_ready", sIn_ready, 0);
      tick();
    end
    #1;
    chk("sat_pass_sOut", sOut, 8'h55);
    chk("sat_pass_sIn_ready", sIn_ready, 1);
    chk("sat_out_valid", out_valid, 1);

    // Backpressure during the prefix
    dIn = {8'hEE, 8'h33, 8'h22, 8'h11}; dIn_count = 3'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sOut_ready = bp_rdy[k];
      #1;
      chk("bp_sOut", sOut, bp_exp[k]);
      chk("bp_sOut_valid", sOut_valid, 1);
      chk("bp_sIn_ready", sIn_ready, 0);
      tick();
    end
    sOut_ready = 1'b0;
    #1;
    chk("bp_pass_sOut", sOut, 8'h55);
    chk("bp_pass_stall", sIn_ready, 0);
    sOut_ready = 1'b1;
    #1;
    chk("bp_pass_go", sIn_ready, 1);

    // Reset in the middle of a prefix
    dIn = {8'h44, 8'h43, 8'h42, 8'h41}; dIn_count = 3'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rmid_w0", sOut, 8'h41);
    tick();
    chk("rmid_w1", sOut, 8'h42);
    nrst = 1'b0;
    #1;
    chk("rmid_in_reset_valid", sOut_valid, 0);
    tick();
    nrst = 1'b1;
    #1;
    chk("rmid_sOut_valid", sOut_valid, 0);
    chk("rmid_in_ready", in_ready, 1);
    chk("rmid_out_valid", out_valid, 0);
    chk("rmid_sIn_ready", sIn_ready, 0);
    tick();
    chk("rmid_idle_still", sOut_valid, 0);

    // Fresh load after reset
    dIn = {8'h00, 8'h00, 8'h62, 8'h61}; dIn_count = 3'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("fresh_w0", sOut, 8'h61);
    tick();
    chk("fresh_w1", sOut, 8'h62);
    chk("fresh_out_valid0", out_valid, 0);
    tick();
    chk("fresh_pass", sOut, 8'h55);
    chk("fresh_ack", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("fresh_ack_clr", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
